// File: rtl/soml_frame_loader_pkg.sv
// rtl/soml_frame_loader_pkg.sv - shared constants and state encoding for the SOML frame loader
package soml_frame_loader_pkg;

    localparam logic [7:0] HDR_BYTE    = 8'hA5;
    localparam int         NUM_H       = 16;
    localparam int         NUM_Y       = 8;
    localparam int         NUM_ENTRIES = NUM_H + NUM_Y;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    // One complex entry is a real word followed by an imaginary word.
    function automatic int bytes_per_entry(input int n);
        return 2 * n / 8;
    endfunction

endpackage

// File: rtl/soml_frame_loader_if.sv
// rtl/soml_frame_loader_if.sv - byte stream in, H/Y memory writes and control pulses out
interface soml_frame_loader_if #(
    parameter int N = 32
) ();

    logic         rx_valid;
    logic [7:0]   rx_data;
    logic         core_busy;

    logic         h_we;
    logic [1:0]   h_row;
    logic [1:0]   h_col;
    logic [N-1:0] h_re;
    logic [N-1:0] h_im;

    logic         y_we;
    logic         y_col;
    logic [1:0]   y_idx;
    logic [N-1:0] y_re;
    logic [N-1:0] y_im;

    logic         start;
    logic         frame_err;
    logic         loading;

    modport master (
        input  rx_valid, rx_data, core_busy,
        output h_we, h_row, h_col, h_re, h_im,
        output y_we, y_col, y_idx, y_re, y_im,
        output start, frame_err, loading
    );

    modport slave (
        output rx_valid, rx_data, core_busy,
        input  h_we, h_row, h_col, h_re, h_im,
        input  y_we, y_col, y_idx, y_re, y_im,
        input  start, frame_err, loading
    );

endinterface

// File: rtl/soml_frame_loader_assembler.sv
// rtl/soml_frame_loader_assembler.sv - MSB-first byte shifter producing one 2N-bit entry word
module soml_byte_assembler
    import soml_frame_loader_pkg::*;
#(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           byte_valid,
    input  logic [7:0]     byte_data,
    output logic [2*N-1:0] word,
    output logic           entry_done
);

    localparam int BPE = bytes_per_entry(N);
    localparam int CW  = (BPE > 1) ? $clog2(BPE) : 1;

    // Only the bytes preceding the current one are stored; the live byte completes the word.
    logic [2*N-9:0] sreg;
    logic [CW-1:0]  cnt;

    assign word       = {sreg, byte_data};
    assign entry_done = byte_valid && !clr && (cnt == CW'(BPE - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (byte_valid) begin
            sreg <= word[2*N-9:0];
            cnt  <= entry_done ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/soml_frame_loader.sv
// rtl/soml_frame_loader.sv - parses framed H/Y packets into decoder memories and launches the decoder
module soml_frame_loader
    import soml_frame_loader_pkg::*;
#(
    parameter int         N           = 32,
    parameter logic [7:0] HDR         = HDR_BYTE,
    parameter int         TIMEOUT_CYC = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    soml_frame_loader_if.master bus
);

    localparam int         IW         = $clog2(TIMEOUT_CYC + 1);
    localparam logic [4:0] LAST_ENTRY = 5'(NUM_ENTRIES - 1);
    localparam logic [4:0] FIRST_Y    = 5'(NUM_H);

    state_t         state;
    state_t         state_nxt;
    logic [4:0]     entry_cnt;
    logic [7:0]     xor_acc;
    logic [IW-1:0]  idle_cnt;
    logic           hdr_ok;
    logic           pay_byte;
    logic           chk_byte;
    logic           timeout;
    logic           entry_done;
    logic [2*N-1:0] word;

    soml_byte_assembler #(.N(N)) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (state != ST_PAYLOAD),
        .byte_valid (pay_byte),
        .byte_data  (bus.rx_data),
        .word       (word),
        .entry_done (entry_done)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (hdr_ok) state_nxt = ST_PAYLOAD;
            ST_PAYLOAD: begin
                if (timeout)                                   state_nxt = ST_IDLE;
                else if (entry_done && entry_cnt == LAST_ENTRY) state_nxt = ST_CHECK;
            end
            ST_CHECK:   if (timeout || chk_byte) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        hdr_ok      = 1'b0;
        pay_byte    = 1'b0;
        chk_byte    = 1'b0;
        timeout     = 1'b0;
        bus.loading = 1'b0;
        case (state)
            ST_IDLE: hdr_ok = bus.rx_valid && (bus.rx_data == HDR) && !bus.core_busy;
            ST_PAYLOAD: begin
                bus.loading = 1'b1;
                pay_byte    = bus.rx_valid;
                timeout     = !bus.rx_valid && (idle_cnt == IW'(TIMEOUT_CYC - 1));
            end
            ST_CHECK: begin
                bus.loading = 1'b1;
                chk_byte    = bus.rx_valid;
                timeout     = !bus.rx_valid && (idle_cnt == IW'(TIMEOUT_CYC - 1));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_cnt     <= '0;
            xor_acc       <= '0;
            idle_cnt      <= '0;
            bus.h_we      <= 1'b0;
            bus.h_row     <= '0;
            bus.h_col     <= '0;
            bus.h_re      <= '0;
            bus.h_im      <= '0;
            bus.y_we      <= 1'b0;
            bus.y_col     <= 1'b0;
            bus.y_idx     <= '0;
            bus.y_re      <= '0;
            bus.y_im      <= '0;
            bus.start     <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            bus.h_we      <= 1'b0;
            bus.y_we      <= 1'b0;
            bus.start     <= 1'b0;
            bus.frame_err <= 1'b0;

            if (state == ST_IDLE || bus.rx_valid) idle_cnt <= '0;
            else                                  idle_cnt <= idle_cnt + 1'b1;

            if (hdr_ok) begin
                entry_cnt <= '0;
                xor_acc   <= '0;
            end

            if (pay_byte) xor_acc <= xor_acc ^ bus.rx_data;

            if (entry_done) begin
                entry_cnt <= entry_cnt + 5'd1;
                if (entry_cnt < FIRST_Y) begin
                    bus.h_we  <= 1'b1;
                    bus.h_row <= entry_cnt[3:2];
                    bus.h_col <= entry_cnt[1:0];
                    bus.h_re  <= word[2*N-1:N];
                    bus.h_im  <= word[N-1:0];
                end else begin
                    // Y entries occupy 16..23, so the low three bits are the offset into Y1/Y2.
                    bus.y_we  <= 1'b1;
                    bus.y_col <= entry_cnt[2];
                    bus.y_idx <= entry_cnt[1:0];
                    bus.y_re  <= word[2*N-1:N];
                    bus.y_im  <= word[N-1:0];
                end
            end

            if (chk_byte) begin
                bus.start     <= (bus.rx_data == xor_acc);
                bus.frame_err <= (bus.rx_data != xor_acc);
            end

            if (timeout) bus.frame_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_soml_frame_loader.sv
// tb/tb_soml_frame_loader.sv - randomized frame bench for soml_frame_loader with a transaction-level model
module tb_soml_frame_loader;
    import soml_frame_loader_pkg::*;

    localparam int N  = 32;
    localparam int TO = 50;
    localparam int NE = NUM_H + NUM_Y;

    typedef struct packed {
        logic         kind;
        logic [1:0]   a1;
        logic [1:0]   a2;
        logic [N-1:0] re;
        logic [N-1:0] im;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    soml_frame_loader_if #(.N(N)) bus ();

    soml_frame_loader #(.N(N), .HDR(8'hA5), .TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    wr_t obs_q[$];
    wr_t exp_q[$];
    wr_t mon_w;
    int n_start = 0, n_err = 0, n_dual = 0;
    int cyc_cnt = 0, last_rx_cyc = 0, err_cyc = 0;
    logic [N-1:0] ent_re [NE];
    logic [N-1:0] ent_im [NE];
    logic [7:0] frame_q[$];

    always @(posedge clk) begin
        cyc_cnt++;
        if (bus.rx_valid) last_rx_cyc = cyc_cnt;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.h_we) begin
                mon_w = '{kind: 1'b0, a1: bus.h_row, a2: bus.h_col, re: bus.h_re, im: bus.h_im};
                obs_q.push_back(mon_w);
            end
            if (bus.y_we) begin
                mon_w = '{kind: 1'b1, a1: {1'b0, bus.y_col}, a2: bus.y_idx, re: bus.y_re, im: bus.y_im};
                obs_q.push_back(mon_w);
            end
            if (bus.h_we && bus.y_we) n_dual++;
            if (bus.start) n_start++;
            if (bus.frame_err) begin
                n_err++;
                err_cyc = cyc_cnt;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        obs_q.delete();
        exp_q.delete();
        n_start = 0;
        n_err   = 0;
        n_dual  = 0;
    endtask

    task automatic rand_entries();
        for (int k = 0; k < NE; k++) begin
            ent_re[k] = $urandom;
            ent_im[k] = $urandom;
        end
    endtask

    task automatic build_frame();
        logic [7:0]     cs;
        logic [2*N-1:0] w;
        cs = 8'h00;
        frame_q.delete();
        frame_q.push_back(8'hA5);
        for (int k = 0; k < NE; k++) begin
            w = {ent_re[k], ent_im[k]};
            for (int b = 2 * N / 8 - 1; b >= 0; b--) begin
                frame_q.push_back(w[b*8 +: 8]);
                cs = cs ^ w[b*8 +: 8];
            end
        end
        frame_q.push_back(cs);
    endtask

    task automatic expect_writes(input int n);
        wr_t w;
        for (int k = 0; k < n; k++) begin
            if (k < NUM_H) begin
                w.kind = 1'b0;
                w.a1   = 2'(k / 4);
                w.a2   = 2'(k % 4);
            end else begin
                w.kind = 1'b1;
                w.a1   = 2'((k - NUM_H) / 4);
                w.a2   = 2'((k - NUM_H) % 4);
            end
            w.re = ent_re[k];
            w.im = ent_im[k];
            exp_q.push_back(w);
        end
    endtask

    task automatic send_raw(input logic [7:0] b, input int gap);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_bytes(input int first, input int last, input int gap);
        for (int i = first; i <= last; i++) send_raw(frame_q[i], gap);
    endtask

    task automatic check_frame(input string tag, input int exp_start, input int exp_err);
        repeat (4) @(negedge clk);
        chk({tag, ":nwr"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("%s:wr%0d", tag, i), obs_q[i], exp_q[i]);
        chk({tag, ":start"}, n_start, exp_start);
        chk({tag, ":err"}, n_err, exp_err);
        chk({tag, ":dual_we"}, n_dual, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ":h_we"}, bus.h_we, 0);
        chk({tag, ":y_we"}, bus.y_we, 0);
        chk({tag, ":start"}, bus.start, 0);
        chk({tag, ":frame_err"}, bus.frame_err, 0);
        chk({tag, ":loading"}, bus.loading, 0);
        chk({tag, ":h_addr"}, {bus.h_row, bus.h_col}, 0);
        chk({tag, ":h_data"}, {bus.h_re, bus.h_im}, 0);
        chk({tag, ":y_addr"}, {bus.y_col, bus.y_idx}, 0);
        chk({tag, ":y_data"}, {bus.y_re, bus.y_im}, 0);
    endtask

    initial begin
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.core_busy = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed frame: H = 0.5*I, Y1 = (0,-.25)x2,(0,.25)x2, Y2 = (.25,0)x4, preceded by garbage
        clear_obs();
        for (int k = 0; k < NE; k++) begin
            ent_re[k] = '0;
            ent_im[k] = '0;
        end
        for (int d = 0; d < 4; d++) ent_re[d * 5] = 32'h0020_0000;
        ent_im[16] = 32'hFFF0_0000;
        ent_im[17] = 32'hFFF0_0000;
        ent_im[18] = 32'h0010_0000;
        ent_im[19] = 32'h0010_0000;
        for (int i = 20; i < 24; i++) ent_re[i] = 32'h0010_0000;
        build_frame();
        expect_writes(NE);
        send_raw(8'h00, 1);
        send_raw(8'hFF, 1);
        send_raw(8'h5A, 1);
        send_bytes(0, frame_q.size() - 1, 1);
        check_frame("valid", 1, 0);

        // Same frame with a corrupted checksum
        clear_obs();
        build_frame();
        frame_q[frame_q.size() - 1] = frame_q[frame_q.size() - 1] ^ 8'h01;
        expect_writes(NE);
        send_bytes(0, frame_q.size() - 1, 1);
        check_frame("badcs", 0, 1);

        // Random frames; the first carries header-valued payload bytes, gaps 0..2
        for (int r = 0; r < 3; r++) begin
            clear_obs();
            rand_entries();
            if (r == 0) ent_re[3] = 32'hA5A5_A5A5;
            build_frame();
            expect_writes(NE);
            send_bytes(0, frame_q.size() - 1, r);
            check_frame($sformatf("rand%0d", r), 1, 0);
        end

        // Stream stalls after 100 bytes: 12 complete entries, then a timeout
        clear_obs();
        rand_entries();
        build_frame();
        expect_writes(12);
        send_bytes(0, 99, 1);
        for (int i = 0; i < 200 && n_err == 0; i++) @(negedge clk);
        chk("timeout:seen", n_err, 1);
        chk("timeout:delay", err_cyc - last_rx_cyc, TO);
        chk("timeout:idle", bus.loading, 0);
        check_frame("timeout", 0, 1);

        clear_obs();
        rand_entries();
        build_frame();
        expect_writes(NE);
        send_bytes(0, frame_q.size() - 1, 1);
        check_frame("after_to", 1, 0);

        // Header while the decoder is busy is ignored, the resend is accepted
        clear_obs();
        rand_entries();
        build_frame();
        bus.core_busy = 1'b1;
        send_bytes(0, frame_q.size() - 1, 1);
        check_frame("busy", 0, 0);
        bus.core_busy = 1'b0;
        clear_obs();
        expect_writes(NE);
        send_bytes(0, frame_q.size() - 1, 1);
        check_frame("busy_resend", 1, 0);

        // Reset in the middle of a frame
        clear_obs();
        rand_entries();
        build_frame();
        send_bytes(0, 59, 1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        @(negedge clk);
        clear_obs();
        rand_entries();
        build_frame();
        expect_writes(NE);
        send_bytes(0, frame_q.size() - 1, 2);
        check_frame("post_rst", 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/soml_frame_loader.md
Name: soml_frame_loader

Overview:
Upstream stage of the SOML decoder core. Consumes the byte stream from the UART receiver, parses one framed packet holding the 4x4 complex channel matrix H and the two 4-element received columns Y1/Y2 (Q22 fixed-point), and writes them into the decoder's H and Y memories. After a frame passes its checksum, it issues a single start pulse that launches the decoder calculation, replacing the FSM kick the bench otherwise forces.

Parameters:
N, 32, word width of each real/imag sample (signed, two's complement, Q22 format); must be a multiple of 8.
HDR, 8'hA5, frame header byte.
TIMEOUT_CYC, 1000000, maximum idle clock cycles between bytes inside a frame before the frame is aborted.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
rx_data  in  8  received byte
core_busy  in  1  high while the decoder is calculating; frames arriving then are dropped
h_we  out  1  one-cycle write strobe for H memory
h_row  out  2  H row index
h_col  out  2  H column index
h_re  out  N  H real part
h_im  out  N  H imaginary part
y_we  out  1  one-cycle write strobe for Y memory
y_col  out  1  0 selects Y1 (y_mem1), 1 selects Y2 (y_mem2)
y_idx  out  2  element index within the column
y_re  out  N  Y real part
y_im  out  N  Y imaginary part
start  out  1  one-cycle pulse after a frame is accepted
frame_err  out  1  one-cycle pulse on checksum mismatch or timeout
loading  out  1  high while a frame is in progress

Behaviour:
- Frame layout: HDR, then 24 complex entries, then 1 checksum byte. Each complex entry is 2*N/8 bytes: the real word MSB-first, then the imaginary word MSB-first. The first 16 entries are H in row-major order (r=0..3, c=0..3). These are followed by Y1 idx0..3 and then Y2 idx0..3. With N=32 the payload is 192 bytes. The checksum is the XOR of all payload bytes, excluding the header.
- States: IDLE, PAYLOAD, CHECK.
  - IDLE: a byte equal to HDR with core_busy=0 moves the FSM to PAYLOAD. All other bytes are ignored, including HDR received while core_busy=1.
  - PAYLOAD: bytes shift into a 2N-bit assembly register. A byte counter runs within the entry, and an entry counter runs 0..23. A running XOR accumulates over payload bytes.
  - CHECK: the next byte is compared with the running XOR. On a match, start pulses; on a mismatch, frame_err pulses. The FSM returns to IDLE in both cases.
- Write timing: in the cycle after the last byte of an entry is accepted, exactly one of h_we or y_we is high for one cycle. Address and data are valid in that same cycle and hold until the next write.
  - Entry k<16: h_row=k[3:2], h_col=k[1:0].
  - Entry k>=16: y_col=(k-16)[2], y_idx=(k-16)[1:0].
- start and frame_err are asserted in the cycle after the checksum byte's rx_valid.
- Writes are not rolled back on error. Because start is withheld, the decoder never consumes a bad frame.
- Timeout: an idle counter resets on every rx_valid while in PAYLOAD or CHECK. When it reaches TIMEOUT_CYC, frame_err pulses for one cycle and the FSM returns to IDLE; partial entries are discarded. The counter is inactive in IDLE.
- A HDR-valued byte inside the payload is treated as data (no resynchronisation).
- core_busy is sampled only in IDLE.
- loading is high in PAYLOAD and CHECK.
- Reset (including mid-frame) clears to the following values: state=IDLE, all counters=0, XOR=0, and all outputs 0.
- rx_valid is never high on consecutive cycles in practice. The block must nevertheless accept back-to-back bytes every cycle without loss.

Decomposition:
- Shared package: HDR, frame entry counts (NUM_H=16, NUM_Y=8), the bytes-per-entry constant, and the state encoding.
- One sub-module is natural: soml_byte_assembler. It is a shift register plus byte counter that emits a 2N-bit word and an entry_done strobe; the loader FSM instantiates it.

Test Plan:
- Full valid frame: H=0.5*I (diagonal real 0x00200000, others 0), Y1=(0,-0.25),(0,-0.25),(0,0.25),(0,0.25), Y2=(0.25,0)x4 -> 16 h_we and 8 y_we with the correct indices and values, then one start pulse, frame_err=0. Chained into the decoder, output 0xCCC.
- Same frame with checksum byte XORed by 0x01 -> all 24 writes occur, frame_err pulses once, start never asserts.
- Stop the stream after byte 100 with TIMEOUT_CYC=50 -> frame_err exactly 50 cycles after the last byte, FSM back in IDLE. A following valid frame produces start.
- Garbage bytes 0x00, 0xFF, 0x5A before HDR -> ignored, no writes. A frame containing payload byte 0xA5 still parses correctly.
- core_busy=1 when HDR arrives -> whole frame ignored, no writes or start. The same frame resent with core_busy=0 is accepted.
- rst asserted at byte 60 -> all outputs are 0 the next cycle, loading=0. A fresh full frame afterwards is accepted with correct addresses starting at h_row=0, h_col=0.
